rvvi_retx_buffer: RTL and testbench

- Parametrised go-back-N retransmission buffer for the hardware RVVI tracer. It replaces the fixed 4-entry active list.
- Sits between the RVVI probe output and the packetizer. Each retired-instruction record gets a sequential frame number and is held until the host acknowledges it cumulatively.
- If an acknowledgement does not arrive within a timeout, the block rewinds and resends every unacknowledged record in order.
- It back-pressures the core when full and raises a sticky fatal flag after too many consecutive retries.

---
 rtl/rvvi_retx_buffer.sv | 231 +++++++++++++++++++++++
 tb/tb_rvvi_retx_buffer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_retx_buffer.sv
// -----------------------------------------------------------------------------
// rvvi_retx_buffer
//
// Go-back-N retransmission buffer between the RVVI probe and the packetizer.
// Every retired-instruction record accepted on the input side is tagged with a
// sequential frame number and held until the host acknowledges it
// cumulatively. If the head of the window makes no progress for TIMEOUT
// cycles, the send pointer rewinds to the oldest unacknowledged record and
// everything is resent in order. After MAX_RETRIES consecutive rewinds with no
// progress, the block enters a sticky FATAL state that only reset clears.
//
// Ports
//   clk, reset_n            clock; synchronous active-low reset
//   in_valid/in_data        probe record offered for storage
//   in_ready                a slot is free (occupancy < DEPTH)
//   stall                   ~in_ready, drives the core ExternalStall
//   out_valid/out_data      record offered to the packetizer
//   out_frame               frame number of out_data
//   out_retx                out_data has been sent before
//   out_ready               packetizer accepts the offered record
//   ack_valid/ack_frame     cumulative host acknowledgement
//   occupancy               records held (unacknowledged plus unsent)
//   retry_count             consecutive rewinds without progress
//   fatal                   sticky; retries exhausted
//
// Frame pointers (all FRAME_COUNT_WIDTH wide, wrapping):
//   head  oldest unacknowledged frame
//   send  next frame to transmit
//   hwm   one past the highest frame ever transmitted
//   tail  next free frame
// Ordering head <= send <= hwm <= tail holds in the modular sense, and
// tail - head never exceeds DEPTH, so differences relative to head are
// unambiguous as long as FRAME_COUNT_WIDTH > $clog2(DEPTH).
// -----------------------------------------------------------------------------
module rvvi_retx_buffer #(
  parameter int unsigned WIDTH             = 512,
  parameter int unsigned DEPTH             = 8,
  parameter int unsigned FRAME_COUNT_WIDTH = 64,
  parameter logic [31:0] TIMEOUT           = 32'd100000,
  parameter int unsigned MAX_RETRIES       = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             in_ready,
  output logic                             stall,
  output logic                             out_valid,
  output logic [WIDTH-1:0]                 out_data,
  output logic [FRAME_COUNT_WIDTH-1:0]     out_frame,
  output logic                             out_retx,
  input  logic                             out_ready,
  input  logic                             ack_valid,
  input  logic [FRAME_COUNT_WIDTH-1:0]     ack_frame,
  output logic [$clog2(DEPTH):0]           occupancy,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
  output logic                             fatal
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
  localparam int unsigned FW = FRAME_COUNT_WIDTH;

  typedef logic [FW-1:0] frame_t;

  localparam frame_t        DEPTH_F    = frame_t'(DEPTH);
  localparam frame_t        ONE_F      = frame_t'(1);
  localparam logic [31:0]   TIMER_LAST = TIMEOUT - 32'd1;
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RETRY_ONE  = RW'(1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_REWIND,
    ST_FATAL
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  frame_t        head_q,  head_d;
  frame_t        send_q,  send_d;
  frame_t        hwm_q,   hwm_d;
  frame_t        tail_q,  tail_d;
  logic [31:0]   timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] out_data_q, out_data_d;

  // ---------------------------------------------------------------------------
  // Handshake decode (all from registered state plus inputs)
  // ---------------------------------------------------------------------------
  frame_t occ_f;
  logic   wr_en;
  logic   xfer;
  logic   holding;
  logic   ack_ok;
  frame_t s_adv;

  assign occ_f     = tail_q - head_q;
  assign in_ready  = (occ_f < DEPTH_F);
  assign stall     = ~in_ready;
  assign occupancy = occ_f[AW:0];

  assign out_valid = (state_q != ST_FATAL) && (send_q != tail_q);
  assign out_frame = send_q;
  // send never passes hwm, so "send < hwm" reduces to inequality. This also
  // keeps out_retx stable while a held record falls behind a fresh ack.
  assign out_retx  = (send_q != hwm_q);
  assign out_data  = out_data_q;

  assign retry_count = retry_q;
  assign fatal       = (state_q == ST_FATAL);

  assign wr_en   = in_valid & in_ready;
  assign xfer    = out_valid & out_ready;
  assign holding = out_valid & ~out_ready;

  // Cumulative ack is meaningful only for frames already sent and not yet
  // acknowledged; stale, duplicate and future frames fall outside the window.
  assign ack_ok = ack_valid && ((ack_frame - head_q) < (hwm_q - head_q));

  assign s_adv = xfer ? (send_q + ONE_F) : send_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    head_d  = head_q;
    hwm_d   = hwm_q;
    tail_d  = wr_en ? (tail_q + ONE_F) : tail_q;
    timer_d = timer_q;
    retry_d = retry_q;

    if (xfer && (send_q == hwm_q)) begin
      hwm_d = send_q + ONE_F;
    end

    if (ack_ok) begin
      head_d = ack_frame + ONE_F;
    end

    // A held record must finish before send may move; once it is free, a
    // pending rewind or an ack that overtook send pulls send up to head.
    send_d = s_adv;
    if (!holding) begin
      if (state_q == ST_REWIND) begin
        send_d  = head_d;
        state_d = ST_RUN;
      end else if ((s_adv - head_d) > (tail_d - head_d)) begin
        send_d = head_d;
      end
    end

    // Progress timer: an ack always wins over an expiry in the same cycle.
    if (ack_ok) begin
      timer_d = '0;
      retry_d = '0;
    end else if ((state_q == ST_RUN) && (head_q != hwm_q)) begin
      if (timer_q == TIMER_LAST) begin
        timer_d = '0;
        if (retry_q == RETRY_MAX) begin
          state_d = ST_FATAL;
        end else begin
          retry_d = retry_q + RETRY_ONE;
          state_d = ST_REWIND;
        end
      end else begin
        timer_d = timer_q + 32'd1;
      end
    end else begin
      timer_d = '0;
    end
  end

  // Output payload register: frozen while a transfer is held, otherwise it
  // tracks the entry that send will point at next cycle. Registering it means
  // a slot freed by an ack and refilled while its record is still held cannot
  // disturb out_data. A write landing on that very frame is forwarded.
  always_comb begin
    out_data_d = out_data_q;
    if (!holding) begin
      if (wr_en && (tail_q == send_d)) begin
        out_data_d = in_data;
      end else begin
        out_data_d = mem[send_d[AW-1:0]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      head_q  <= '0;
      send_q  <= '0;
      hwm_q   <= '0;
      tail_q  <= '0;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      send_q  <= send_d;
      hwm_q   <= hwm_d;
      tail_q  <= tail_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  // NOTE: payload storage has no reset; out_valid and the pointers already
  // mark which entries are meaningful, and leaving it unreset keeps it a
  // plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[tail_q[AW-1:0]] <= in_data;
    end
    out_data_q <= out_data_d;
  end

endmodule

// File: tb/tb_rvvi_retx_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for rvvi_retx_buffer (WIDTH=32, DEPTH=8, FRAME_COUNT_WIDTH=4,
// TIMEOUT=16, MAX_RETRIES=2). A transaction-level model keeps absolute,
// unbounded frame numbers in plain ints and the payloads in an associative
// array keyed by frame; every cycle the DUT outputs are compared against it.
// Directed phases follow the test plan, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_rvvi_retx_buffer;

  localparam int W   = 32;
  localparam int D   = 8;
  localparam int FCW = 4;
  localparam int TO  = 16;
  localparam int MR  = 2;

  localparam int M_RUN    = 0;
  localparam int M_REWIND = 1;
  localparam int M_FATAL  = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic           stall;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [FCW-1:0] out_frame;
  logic           out_retx;
  logic           out_ready;
  logic           ack_valid;
  logic [FCW-1:0] ack_frame;
  logic [3:0]     occupancy;
  logic [1:0]     retry_count;
  logic           fatal;

  rvvi_retx_buffer #(
    .WIDTH            (W),
    .DEPTH            (D),
    .FRAME_COUNT_WIDTH(FCW),
    .TIMEOUT          (32'(TO)),
    .MAX_RETRIES      (MR)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .stall      (stall),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_frame  (out_frame),
    .out_retx   (out_retx),
    .out_ready  (out_ready),
    .ack_valid  (ack_valid),
    .ack_frame  (ack_frame),
    .occupancy  (occupancy),
    .retry_count(retry_count),
    .fatal      (fatal)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state (absolute frame numbers, never wrapped)
  int           mh, ms, mhwm, mt, mtimer, mretry, mst;
  logic [W-1:0] mpay [int];
  bit           m_wr;

  // Observations captured at the compare point of the last cycle
  bit           obs_tr;
  bit           obs_retx;
  logic [3:0]   obs_frame;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; ms = 0; mhwm = 0; mt = 0;
    mtimer = 0; mretry = 0; mst = M_RUN;
    mpay.delete();
  endtask

  task automatic compare_outputs();
    bit exp_ir;
    bit exp_ov;
    exp_ir = (mt - mh) < D;
    exp_ov = (mst != M_FATAL) && (ms != mt);
    check("in_ready",    64'(in_ready),    64'(exp_ir));
    check("stall",       64'(stall),       64'(!exp_ir));
    check("occupancy",   64'(occupancy),   64'(mt - mh));
    check("retry_count", 64'(retry_count), 64'(mretry));
    check("fatal",       64'(fatal),       64'(mst == M_FATAL));
    check("out_valid",   64'(out_valid),   64'(exp_ov));
    if (exp_ov) begin
      check("out_frame", 64'(out_frame), 64'(ms % 16));
      check("out_data",  64'(out_data),  64'(mpay[ms]));
      check("out_retx",  64'(out_retx),  64'(ms < mhwm));
    end
  endtask

  // One clock of the specification's rules on absolute frame numbers.
  task automatic model_step();
    int         h0, hwm0, s0, t0, st0, a, ns;
    bit         ir, ov, tr, hold, aok;
    logic [3:0] d;
    h0 = mh; hwm0 = mhwm; s0 = ms; t0 = mt; st0 = mst;
    ir   = (t0 - h0) < D;
    ov   = (st0 != M_FATAL) && (s0 != t0);
    m_wr = in_valid && ir;
    tr   = ov && out_ready;
    hold = ov && !out_ready;
    d    = ack_frame - 4'(h0);
    a    = h0 + int'(d);
    aok  = ack_valid && (a < hwm0);

    if (m_wr) begin
      mpay[t0] = in_data;
      mt = t0 + 1;
    end
    ns = s0;
    if (tr) begin
      ns = s0 + 1;
      if (s0 + 1 > mhwm) mhwm = s0 + 1;
    end
    if (aok) mh = a + 1;
    if (!hold) begin
      if (st0 == M_REWIND) begin
        ns  = mh;
        mst = M_RUN;
      end else if (ns < mh) begin
        ns = mh;
      end
    end
    ms = ns;

    if (aok) begin
      mtimer = 0;
      mretry = 0;
    end else if (st0 == M_RUN && h0 != hwm0) begin
      if (mtimer == TO - 1) begin
        mtimer = 0;
        if (mretry == MR) mst = M_FATAL;
        else begin
          mretry++;
          mst = M_REWIND;
        end
      end else begin
        mtimer++;
      end
    end else begin
      mtimer = 0;
    end
  endtask

  task automatic cycle();
    compare_outputs();
    obs_tr    = out_valid && out_ready;
    obs_frame = out_frame;
    obs_retx  = out_retx;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    ack_valid = 1'b0;
    ack_frame = '0;
  endtask

  // Inputs are left as they are so reset can land mid-handshake.
  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int pending;
    int nretx;
    int nsent;
    int r;

    clear_inputs();
    do_reset();

    // ---- reset state ----
    check("rst_out_valid", 64'(out_valid),   64'(0));
    check("rst_in_ready",  64'(in_ready),    64'(1));
    check("rst_occupancy", 64'(occupancy),   64'(0));
    check("rst_fatal",     64'(fatal),       64'(0));
    check("rst_retry",     64'(retry_count), 64'(0));

    // ---- full / stall ----
    out_ready = 1'b1;
    pending = 10;
    nsent = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = (pending > 0);
      in_data  = $urandom;
      cycle();
      if (m_wr) pending--;
      if (obs_tr) begin
        check("full_send_frame", 64'(obs_frame), 64'(nsent));
        nsent++;
      end
    end
    check("full_sent_count", 64'(nsent),     64'(8));
    check("full_occupancy",  64'(occupancy), 64'(8));
    check("full_in_ready",   64'(in_ready),  64'(0));
    check("full_stall",      64'(stall),     64'(1));
    ack_valid = 1'b1; ack_frame = 4'd3;
    in_valid = (pending > 0); in_data = $urandom;
    cycle();
    if (m_wr) pending--;
    ack_valid = 1'b0;
    check("ack3_occupancy", 64'(occupancy), 64'(4));
    check("ack3_in_ready",  64'(in_ready),  64'(1));
    for (int i = 0; i < 4; i++) begin
      in_valid = (pending > 0);
      in_data  = $urandom;
      cycle();
      if (m_wr) pending--;
    end
    check("full_refill_occ", 64'(occupancy), 64'(6));
    in_valid = 1'b0;
    ack_valid = 1'b1; ack_frame = 4'd9;
    cycle();
    ack_valid = 1'b0;
    check("ack9_occupancy", 64'(occupancy), 64'(0));

    // ---- cumulative and stale acks ----
    clear_inputs();
    do_reset();
    out_ready = 1'b1;
    pending = 6;
    for (int i = 0; i < 8; i++) begin
      in_valid = (pending > 0);
      in_data  = $urandom;
      cycle();
      if (m_wr) pending--;
    end
    in_valid = 1'b0;
    ack_valid = 1'b1; ack_frame = 4'd4;
    cycle();
    check("ack4_occupancy", 64'(occupancy), 64'(1));
    ack_frame = 4'd2;
    cycle();
    check("stale_ack_occ", 64'(occupancy), 64'(1));
    ack_frame = 4'd9;
    cycle();
    check("future_ack_occ", 64'(occupancy), 64'(1));
    ack_frame = 4'd5;
    cycle();
    ack_valid = 1'b0;
    check("ack5_occupancy", 64'(occupancy), 64'(0));

    // ---- timeout rewind ----
    clear_inputs();
    do_reset();
    out_ready = 1'b1;
    pending = 4;
    nretx = 0;
    for (int i = 0; i < 60 && nretx < 4; i++) begin
      in_valid = (pending > 0);
      in_data  = $urandom;
      cycle();
      if (m_wr) pending--;
      if (obs_tr && obs_retx) begin
        check("retx_frame", 64'(obs_frame), 64'(nretx));
        if (nretx == 0) check("retx_retry_count", 64'(retry_count), 64'(1));
        nretx++;
      end
    end
    check("retx_count", 64'(nretx), 64'(4));
    ack_valid = 1'b1; ack_frame = 4'd3;
    cycle();
    ack_valid = 1'b0;
    check("retx_ack_retry", 64'(retry_count), 64'(0));
    check("retx_ack_occ",   64'(occupancy),   64'(0));

    // ---- hold during rewind ----
    clear_inputs();
    do_reset();
    pending = 3;
    for (int i = 0; i < 30; i++) begin
      in_valid  = (pending > 0);
      in_data   = $urandom;
      out_ready = (ms != 2);
      cycle();
      if (m_wr) pending--;
      if (i > 5) check("hold_frame", 64'(out_frame), 64'(2));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    cycle();
    check("hold_release_tr",    64'(obs_tr),    64'(1));
    check("hold_release_frame", 64'(obs_frame), 64'(2));
    cycle();
    check("rewind_head_frame", 64'(obs_frame), 64'(0));
    check("rewind_head_retx",  64'(obs_retx),  64'(1));

    // ---- fatal ----
    clear_inputs();
    do_reset();
    out_ready = 1'b1;
    pending = 2;
    for (int i = 0; i < 200 && !fatal; i++) begin
      in_valid = (pending > 0);
      in_data  = $urandom;
      cycle();
      if (m_wr) pending--;
    end
    check("fatal_set",       64'(fatal),       64'(1));
    check("fatal_out_valid", 64'(out_valid),   64'(0));
    check("fatal_retry",     64'(retry_count), 64'(2));
    ack_valid = 1'b1; ack_frame = 4'd0;
    cycle();
    ack_valid = 1'b0;
    check("fatal_sticky", 64'(fatal), 64'(1));
    pending = 20;
    for (int i = 0; i < 12; i++) begin
      in_valid = (pending > 0);
      in_data  = $urandom;
      cycle();
      if (m_wr) pending--;
    end
    check("fatal_full_ready", 64'(in_ready),  64'(0));
    check("fatal_full_occ",   64'(occupancy), 64'(8));
    do_reset();
    check("fatal_rst_fatal", 64'(fatal),     64'(0));
    check("fatal_rst_occ",   64'(occupancy), 64'(0));
    check("fatal_rst_valid", 64'(out_valid), 64'(0));
    check("fatal_rst_ready", 64'(in_ready),  64'(1));

    // ---- frame counter wrap ----
    clear_inputs();
    do_reset();
    out_ready = 1'b1;
    pending = 40;
    nsent = 0;
    for (int i = 0; i < 150 && nsent < 40; i++) begin
      in_valid  = (pending > 0);
      in_data   = $urandom;
      ack_valid = (mhwm > mh);
      ack_frame = 4'(mhwm - 1);
      cycle();
      if (m_wr) pending--;
      if (obs_tr) begin
        check("wrap_frame", 64'(obs_frame), 64'(nsent % 16));
        check("wrap_retx",  64'(obs_retx),  64'(0));
        nsent++;
      end
    end
    check("wrap_count", 64'(nsent), 64'(40));
    in_valid  = 1'b0;
    ack_valid = 1'b1;
    ack_frame = 4'(mhwm - 1);
    cycle();
    ack_valid = 1'b0;
    check("wrap_final_occ", 64'(occupancy), 64'(0));

    // ---- randomized traffic against the model ----
    clear_inputs();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      ack_valid = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 3);
      if (r <= 1)      ack_frame = 4'(mh + $urandom_range(0, mhwm - mh));
      else if (r == 2) ack_frame = 4'(mh - $urandom_range(1, 4));
      else             ack_frame = 4'(mhwm + $urandom_range(0, 4));
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
        check("rnd_reset_valid", 64'(out_valid), 64'(0));
      end else begin
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
